// File: rtl/router_pkg.sv
// router_pkg: shared widths, address constants and control-FSM state encodings for the router
package router_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = '1;
  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } fsm_state_t;
endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: running XOR parity, packet parity capture and mismatch flag
module router_parity_chk #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  pkt_valid,
  input  logic                  parity_done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] header,
  output logic                  err
);
  import router_pkg::*;
  logic [DATA_WIDTH-1:0] internal_parity, packet_parity;
  logic done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      internal_parity <= '0;
      packet_parity   <= '0;
      done_q          <= 1'b0;
      err             <= 1'b0;
    end else begin
      internal_parity <= detect_add ? '0 :
                         lfd_state ? internal_parity ^ header :
                         (ld_state && pkt_valid && !full_state) ? internal_parity ^ data_in :
                         internal_parity;
      if (ld_state && !pkt_valid) packet_parity <= data_in;
      done_q <= parity_done;
      // compare only on the rising edge of parity_done, then hold until the next packet
      err <= detect_add ? 1'b0 :
             (parity_done && !done_q) ? (internal_parity != packet_parity) :
             err;
    end
  end
endmodule

// File: rtl/router_reg.sv
// router_reg: header latch, dout/hold byte mux and parity status beside the router control FSM
module router_reg #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = router_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);
  import router_pkg::*;
  localparam logic [ADDR_WIDTH-1:0] ADDR_BAD = '1;
  logic [DATA_WIDTH-1:0] header, hold;
  logic hdr_ok;
  assign hdr_ok = data_in[ADDR_WIDTH-1:0] != ADDR_BAD;
  always_ff @(posedge clk) begin
    if (reset) begin
      dout          <= '0;
      hold          <= '0;
      header        <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
    end else begin
      if (detect_add && pkt_valid && hdr_ok) header <= data_in;
      // a byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL
      if (lfd_state) dout <= header;
      else if (ld_state && !fifo_full) dout <= data_in;
      else if (ld_state) hold <= data_in;
      else if (laf_state) dout <= hold;
      low_pkt_valid <= rst_int_reg ? 1'b0 : (ld_state && !pkt_valid) ? 1'b1 : low_pkt_valid;
      parity_done <= detect_add ? 1'b0 :
                     ((ld_state && !fifo_full && !pkt_valid) ||
                      (laf_state && low_pkt_valid && !parity_done)) ? 1'b1 :
                     parity_done;
    end
  end
  router_parity_chk #(.DATA_WIDTH(DATA_WIDTH)) u_parity_chk (
    .clk         (clk),
    .reset       (reset),
    .detect_add  (detect_add),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .full_state  (full_state),
    .pkt_valid   (pkt_valid),
    .parity_done (parity_done),
    .data_in     (data_in),
    .header      (header),
    .err         (err)
  );
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: scoreboard bench for router_reg driven with hand-built FSM strobe sequences
module tb_router_reg;
  localparam logic [6:0] IDL = 7'h00, RST = 7'h40, DA = 7'h20, LFD = 7'h10,
                         LD = 7'h08, LAF = 7'h04, FUL = 7'h02, RI = 7'h01;
  logic clk = 1'b0;
  logic reset, pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic parity_done, low_pkt_valid, err;
  int checks = 0, failures = 0;
  logic [7:0] sb[$];
  always #5 clk = ~clk;
  router_reg dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .dout          (dout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // drive one cycle of strobes; e >= 0 is the byte expected on dout after this edge
  task automatic st(input logic [6:0] s, input logic pv, input logic [7:0] d, input logic ff, input int e);
    logic [7:0] x;
    {reset, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
    if (e >= 0) sb.push_back(8'(e));
    @(posedge clk);
    #1;
    if (e >= 0) begin
      x = sb.pop_front();
      chk("dout", dout, x);
    end
  endtask
  task automatic pkt(input logic [7:0] par, input logic exp_err);
    st(DA, 1, 8'h0D, 0, -1);
    chk("err_clr_on_da", err, 0);
    chk("pdone_clr_on_da", parity_done, 0);
    st(LFD, 1, 8'h11, 0, 'h0D);
    st(LD, 1, 8'h11, 0, 'h11);
    st(LD, 1, 8'h22, 0, 'h22);
    st(LD, 1, 8'h33, 0, 'h33);
    st(LD, 0, par, 0, int'(par));
    chk("pdone_set", parity_done, 1);
    chk("lpv_set", low_pkt_valid, 1);
    st(IDL, 0, par, 0, -1);
    chk("err_pkt", err, exp_err);
    st(RI, 0, 8'h00, 0, -1);
    chk("err_cpe", err, exp_err);
    chk("lpv_clr", low_pkt_valid, 0);
  endtask
  initial begin
    st(RST, 0, 8'h00, 0, -1);
    chk("rst_dout", dout, 0);
    chk("rst_pdone", parity_done, 0);
    chk("rst_lpv", low_pkt_valid, 0);
    chk("rst_err", err, 0);
    pkt(8'h0D, 0);
    pkt(8'h0C, 1);
    pkt(8'h0D, 0);
    // FIFO full on the 0x22 byte
    st(DA, 1, 8'h0D, 0, -1);
    st(LFD, 1, 8'h11, 0, 'h0D);
    st(LD, 1, 8'h11, 0, 'h11);
    st(LD, 1, 8'h22, 1, -1);
    chk("full_dout_hold", dout, 8'h11);
    st(FUL, 1, 8'h33, 1, -1);
    chk("full_state_dout", dout, 8'h11);
    st(LAF, 1, 8'h33, 0, 'h22);
    st(LD, 1, 8'h33, 0, 'h33);
    st(LD, 0, 8'h0D, 0, 'h0D);
    chk("full_pdone", parity_done, 1);
    st(IDL, 0, 8'h00, 0, -1);
    chk("full_err", err, 0);
    st(RI, 0, 8'h00, 0, -1);
    // pkt_valid drops while FIFO is full
    st(DA, 1, 8'h0D, 0, -1);
    st(LFD, 1, 8'h11, 0, 'h0D);
    st(LD, 1, 8'h11, 0, 'h11);
    st(LD, 1, 8'h22, 0, 'h22);
    st(LD, 1, 8'h33, 0, 'h33);
    st(LD, 0, 8'h0D, 1, -1);
    chk("lv_pdone_low", parity_done, 0);
    chk("lv_lpv", low_pkt_valid, 1);
    chk("lv_dout", dout, 8'h33);
    st(FUL, 0, 8'h00, 1, -1);
    chk("lv_pdone_full", parity_done, 0);
    st(LAF, 0, 8'h00, 0, 'h0D);
    chk("lv_pdone_laf", parity_done, 1);
    st(IDL, 0, 8'h00, 0, -1);
    chk("lv_err", err, 0);
    st(RI, 0, 8'h00, 0, -1);
    chk("lv_lpv_clr", low_pkt_valid, 0);
    // invalid address after a valid header 0x15
    st(DA, 1, 8'h15, 0, -1);
    st(DA, 1, 8'h07, 0, -1);
    chk("inv_dout", dout, 8'h0D);
    st(LFD, 1, 8'h15, 0, 'h15);
    st(LD, 0, 8'h15, 0, 'h15);
    chk("inv_pdone", parity_done, 1);
    st(IDL, 0, 8'h00, 0, -1);
    chk("inv_err", err, 0);
    st(RI, 0, 8'h00, 0, -1);
    // reset mid-packet
    st(DA, 1, 8'h0D, 0, -1);
    st(LFD, 1, 8'h11, 0, 'h0D);
    st(LD, 1, 8'h11, 0, 'h11);
    st(LD, 0, 8'h22, 1, -1);
    chk("pre_rst_lpv", low_pkt_valid, 1);
    st(RST | LD, 0, 8'h33, 0, -1);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_lpv", low_pkt_valid, 0);
    chk("mid_rst_pdone", parity_done, 0);
    chk("mid_rst_err", err, 0);
    st(LAF, 0, 8'h00, 0, 0);
    pkt(8'h0D, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
